// File: rtl/fetch_pkg.sv
// Shared types and instruction field positions for the fetch unit.
// The HALT state only exists when FETCH_HALT_EN is defined.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        HOLD    = 3'd2,
        RESOLVE = 3'd3
`ifdef FETCH_HALT_EN
        ,
        HALT    = 3'd4
`endif
    } fetch_state_t;

    localparam logic [3:0] OP_HALT    = 4'b1111;
    localparam int         OPCODE_MSB = 31;
    localparam int         OPCODE_LSB = 28;
    localparam int         IMM_MSB    = 15;
    localparam int         IMM_LSB    = 0;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump target, taken branch, or pc+1.
// All arithmetic wraps modulo 2^PC_W.
module pc_next_calc #(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_target,
    input  logic [15:0]     i_imm,
    input  logic            i_jump,
    input  logic            i_beq,
    input  logic            i_bne,
    input  logic            i_alu_zero,
    output logic [PC_W-1:0] o_next_pc
);

    logic [PC_W-1:0] w_seq;
    logic [PC_W-1:0] w_off;
    logic [PC_W-1:0] w_branch;
    logic            w_taken;

    // Sign-extend (or truncate) the 16-bit branch offset to the PC width.
    generate
        if (PC_W > 16) begin : g_ext
            assign w_off = {{(PC_W-16){i_imm[15]}}, i_imm};
        end else if (PC_W == 16) begin : g_eq
            assign w_off = i_imm;
        end else begin : g_trunc
            assign w_off = i_imm[PC_W-1:0];
        end
    endgenerate

    assign w_seq    = i_pc + PC_W'(1);
    assign w_branch = w_seq + w_off;
    assign w_taken  = (i_beq & i_alu_zero) | (i_bne & ~i_alu_zero);

    always_comb begin
        o_next_pc = w_seq;
        if (i_jump) begin
            o_next_pc = i_target;
        end else if (w_taken) begin
            o_next_pc = w_branch;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: IDLE -> FETCH -> HOLD -> RESOLVE -> FETCH.
// Optional halt-on-OP_HALT support is compiled in with FETCH_HALT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [3:0]      opcode,
    output logic [PC_W-1:0] pc,
    input  logic            resolve,
    input  logic            jump,
    input  logic            beq,
    input  logic            bne,
    input  logic            alu_zero,
    output logic            halted
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_instr_valid;
    logic [PC_W-1:0] w_next_pc;

    pc_next_calc #(
        .PC_W(PC_W)
    ) u_pc_next_calc (
        .i_pc       (r_pc),
        .i_target   (r_instr[PC_W-1:0]),
        .i_imm      (r_instr[IMM_MSB:IMM_LSB]),
        .i_jump     (jump),
        .i_beq      (beq),
        .i_bne      (bne),
        .i_alu_zero (alu_zero),
        .o_next_pc  (w_next_pc)
    );

`ifdef FETCH_HALT_EN
    logic r_halted;
    assign halted = r_halted;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            r_halted      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (resolve) begin
`ifdef FETCH_HALT_EN
                        if (r_instr[OPCODE_MSB:OPCODE_LSB] == OP_HALT) begin
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= FETCH;
                        end
`else
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
`endif
                    end
                end
`ifdef FETCH_HALT_EN
                HALT: begin
                    r_state <= HALT;
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The request is a pure decode of the registered state, so it drops
    // in the same cycle the FSM leaves FETCH.
    assign imem_req    = (r_state == FETCH);
    assign imem_addr   = (r_state == FETCH) ? r_pc : '0;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign opcode      = r_instr[OPCODE_MSB:OPCODE_LSB];
    assign pc          = r_pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16: program counter width, word-addressed.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded at reset.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port imem_req  output  1: instruction memory read request.
REQ-006 SHALL have port imem_addr  output  PC_W: read address, equal to the current PC.
REQ-007 SHALL have port imem_ack  input  1: read data valid on imem_rdata this cycle.
REQ-008 SHALL have port imem_rdata  input  32: instruction word.
REQ-009 SHALL have port instr_valid  output  1: instr, opcode and pc hold a valid instruction.
REQ-010 SHALL have port instr_ready  input  1: the decode/control stage accepts the instruction.
REQ-011 SHALL have port instr  output  32: the registered instruction word.
REQ-012 SHALL have port opcode  output  4: instr[31:28], fed to the control unit.
REQ-013 SHALL have port pc  output  PC_W: address of the held instruction.
REQ-014 SHALL have port resolve  input  1: strobe; the branch outcome is valid this cycle.
REQ-015 SHALL have port jump, beq, bne  input  1 each: control-unit flags for the held instruction.
REQ-016 SHALL have port alu_zero  input  1: ALU zero flag for the held instruction.
REQ-017 SHALL have port halted  output  1: the core has stopped fetching.

Function
REQ-018 SHALL implement the states IDLE, FETCH, HOLD, RESOLVE, plus HALT when FETCH_HALT_EN is defined.
REQ-019 SHALL move from IDLE to FETCH unconditionally on the next clock.
REQ-020 SHALL drive imem_req=1 and imem_addr=pc combinationally from state==FETCH, and 0 otherwise.
REQ-021 SHALL, in FETCH with imem_ack=1, capture imem_rdata into instr and enter HOLD; instr_valid becomes 1 on the following cycle (latency 1 after ack).
REQ-022 SHALL, in FETCH with imem_ack=0, stay in FETCH with address stable.
REQ-023 SHALL, in HOLD, assert instr_valid and keep instr and pc stable until instr_ready=1, then enter RESOLVE.
REQ-024 SHALL keep instr_valid=0 in RESOLVE, and hold instr and pc there, which the downstream stage may read.
REQ-025 SHALL, in RESOLVE with resolve=1, load the next PC and enter FETCH.
REQ-026 SHALL compute the next PC by priority: jump -> instr[PC_W-1:0]; beq&alu_zero or bne&~alu_zero -> pc+1+sign-extend(instr[15:0]); otherwise pc+1.
REQ-027 SHALL perform all PC arithmetic modulo 2^PC_W (wrap-around, no error).
REQ-028 SHALL give jump priority over beq, and beq priority over bne, when more than one flag is asserted.
REQ-029 SHALL ignore imem_ack outside FETCH, instr_ready outside HOLD, and resolve outside RESOLVE.

Reset
REQ-030 SHALL, on a clock edge with rst_n=0, set: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0.
REQ-031 SHALL abandon any outstanding fetch when reset is asserted mid-operation, and SHALL ignore an imem_ack arriving in the IDLE state that follows.
REQ-032 SHALL take reset priority over every other input in the same cycle.

Configuration
REQ-033 SHALL compile the halt feature in only when FETCH_HALT_EN is defined; in that case, resolve on opcode 4'b1111 enters HALT, where halted=1, imem_req=0 and the unit waits for reset.
REQ-034 SHALL, without FETCH_HALT_EN, treat opcode 4'b1111 as sequential (pc+1) and tie halted to 0.

Structure
REQ-035 SHALL place the state enumeration, OP_HALT (4'b1111) and the instruction field positions in the shared package fetch_pkg.
REQ-036 SHALL implement next-PC selection as the combinational sub-module pc_next_calc.

Verification
REQ-037 SHALL cover: reset, RESET_PC=0, memory acks after 2 cycles, rdata=32'h2123_0000 -> imem_addr=0; instr_valid rises 1 cycle after ack; opcode=4'h2.
REQ-038 SHALL cover: pc=5, beq=1, alu_zero=1, instr[15:0]=16'hFFFD -> next imem_addr=3.
REQ-039 SHALL cover: pc=5, bne=1, alu_zero=1 -> next imem_addr=6; then jump=1, beq=1, instr[15:0]=16'h0040 -> imem_addr=16'h0040.
REQ-040 SHALL cover: pc=16'hFFFF, sequential -> imem_addr=0; instr_ready held 0 for 4 cycles -> instr stable, no new request.
REQ-041 SHALL cover: rst_n=0 while in FETCH -> imem_req=0 next cycle, pc=RESET_PC; a late ack is ignored.
REQ-042 SHALL cover, with FETCH_HALT_EN: opcode 4'hF resolved -> halted=1, imem_req stays 0 for 10 cycles.
